// File: rtl/column_select_input_pkg.sv
// column_select_input_pkg: shared state encoding and codes for the column input stage
package column_select_input_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_WAIT_REL,
    S_REJECT
  } state_e;

  localparam logic [3:0] COL_NONE     = 4'b1111;
  localparam logic [1:0] GAME_PLAYING = 2'b00;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/column_select_input_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter for one pushbutton
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic db_o
);

  logic             meta_q, sync_q, db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // count cycles the synchronised input disagrees with the debounced level; flip and restart at the threshold
  always_comb begin
    cnt_d = (sync_q == db_q || cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) ? '0 : cnt_inc;
    db_d  = (sync_q != db_q && cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) ? ~db_q : db_q;
  end

  // synchroniser chain and debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/column_select_input.sv
// column_select_input: debounced pushbuttons to one-hot column code and single move strobe
module column_select_input
  import column_select_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [1:0] game_status,
  output logic [3:0] in_column,
  output logic       enable,
  output logic       err_multi,
  output logic [3:0] btn_db
);

  state_e     state_q;
  logic [3:0] col_q;
  logic       en_q, err_q;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i (clk),
      .rst_ni(reset),
      .btn_i (btn_raw[i]),
      .db_o  (btn_db[i])
    );
  end

  // classify each press: one move per press-and-release, multi-press rejected, lockout when game over
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= COL_NONE;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (btn_db != 4'b0000) begin
            if (!is_onehot(btn_db)) begin
              state_q <= S_REJECT;
              err_q   <= 1'b1;
            end else if (game_status == GAME_PLAYING) begin
              state_q <= S_SETUP;
              col_q   <= ~btn_db;
            end else begin
              state_q <= S_WAIT_REL;
            end
          end
        end
        S_SETUP: begin
          state_q <= S_FIRE;
          en_q    <= 1'b1;
        end
        S_FIRE: state_q <= S_WAIT_REL;
        default: begin
          if (btn_db == 4'b0000) begin
            state_q <= S_IDLE;
            col_q   <= COL_NONE;
          end
        end
      endcase
    end
  end

  assign in_column = col_q;
  assign enable    = en_q;
  assign err_multi = err_q;

endmodule

// File: tb/tb_column_select_input.sv
// tb_column_select_input: directed and random stimulus against a behavioural model
module tb_column_select_input;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [1:0] game_status = 2'b00;
  logic [3:0] in_column, btn_db;
  logic       enable, err_multi;

  int tests = 0;
  int fails = 0;

  column_select_input #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .game_status(game_status),
    .in_column  (in_column),
    .enable     (enable),
    .err_multi  (err_multi),
    .btn_db     (btn_db)
  );

  always #5 clk = ~clk;

  // behavioural model: raw history window decides debounced levels, phase tracks one move per press
  logic [3:0] h [8];
  logic [3:0] m_db, m_col;
  logic       m_en, m_err;
  int         phase;
  int         en_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] en_col = 4'b1111;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) h[k] = 4'b0000;
      m_db = 4'b0000; m_col = 4'b1111; m_en = 1'b0; m_err = 1'b0; phase = 0;
    end else begin
      logic [3:0] dbp;
      dbp = m_db;
      for (int k = 7; k > 0; k--) h[k] = h[k-1];
      h[0] = btn_raw;
      for (int b = 0; b < 4; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 2; k < 2 + DEB; k++) if (h[k][b] == dbp[b]) all_diff = 1'b0;
        if (all_diff) m_db[b] = ~dbp[b];
      end
      m_en = 1'b0;
      m_err = 1'b0;
      if (phase == 0) begin
        if (dbp != 4'b0000) begin
          if ($countones(dbp) != 1) begin m_err = 1'b1; phase = 3; end
          else if (game_status == 2'b00) begin m_col = ~dbp; phase = 1; end
          else phase = 3;
        end
      end else if (phase == 1) begin
        m_en = 1'b1; phase = 2;
      end else if (phase == 2) begin
        phase = 3;
      end else if (dbp == 4'b0000) begin
        phase = 0; m_col = 4'b1111;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("in_column", 32'(in_column), 32'(m_col));
      chk("enable", 32'(enable), 32'(m_en));
      chk("err_multi", 32'(err_multi), 32'(m_err));
      chk("btn_db", 32'(btn_db), 32'(m_db));
      if (m_en) begin en_cnt++; en_col = m_col; end
      if (m_err) err_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e0, r0;

  initial begin
    cyc(2);
    chk("rst_in_column", 32'(in_column), 32'hF);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_err_multi", 32'(err_multi), 32'h0);
    chk("rst_btn_db", 32'(btn_db), 32'h0);
    reset = 1'b1;
    cyc(3);
    // clean press of column 0
    e0 = en_cnt;
    btn_raw = 4'b0001;
    cyc(5);
    chk("t1_db_early", 32'(btn_db), 32'h0);
    cyc(1);
    chk("t1_db", 32'(btn_db), 32'h1);
    cyc(1);
    chk("t1_col", 32'(in_column), 32'hE);
    chk("t1_en_pre", 32'(enable), 32'h0);
    cyc(1);
    chk("t1_en", 32'(enable), 32'h1);
    cyc(1);
    chk("t1_en_post", 32'(enable), 32'h0);
    chk("t1_col_hold", 32'(in_column), 32'hE);
    cyc(11);
    btn_raw = 4'b0000;
    cyc(12);
    chk("t1_col_rel", 32'(in_column), 32'hF);
    chk("t1_count", 32'(en_cnt - e0), 32'd1);
    // bouncing press of column 2
    e0 = en_cnt;
    for (int k = 0; k < 6; k++) begin
      btn_raw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      cyc(2);
    end
    btn_raw = 4'b0100;
    cyc(20);
    btn_raw = 4'b0000;
    cyc(12);
    chk("t2_count", 32'(en_cnt - e0), 32'd1);
    chk("t2_col", 32'(en_col), 32'hB);
    // multi press rejected, then a single press of column 3
    e0 = en_cnt; r0 = err_cnt;
    btn_raw = 4'b0011;
    cyc(15);
    chk("t3_err", 32'(err_cnt - r0), 32'd1);
    chk("t3_no_en", 32'(en_cnt - e0), 32'd0);
    chk("t3_col", 32'(in_column), 32'hF);
    btn_raw = 4'b0000;
    cyc(12);
    btn_raw = 4'b1000;
    cyc(15);
    btn_raw = 4'b0000;
    cyc(12);
    chk("t3_count", 32'(en_cnt - e0), 32'd1);
    chk("t3_col3", 32'(en_col), 32'h7);
    // lockout while the game is decided
    e0 = en_cnt;
    game_status = 2'b01;
    btn_raw = 4'b0010;
    cyc(15);
    chk("t4_locked", 32'(en_cnt - e0), 32'd0);
    game_status = 2'b00;
    btn_raw = 4'b0000;
    cyc(12);
    btn_raw = 4'b0010;
    cyc(15);
    btn_raw = 4'b0000;
    cyc(12);
    chk("t4_count", 32'(en_cnt - e0), 32'd1);
    chk("t4_col", 32'(en_col), 32'hD);
    // second button while held
    e0 = en_cnt;
    btn_raw = 4'b0001;
    cyc(10);
    btn_raw = 4'b0101;
    cyc(15);
    btn_raw = 4'b0100;
    cyc(12);
    chk("t5_count_held", 32'(en_cnt - e0), 32'd1);
    chk("t5_col", 32'(en_col), 32'hE);
    btn_raw = 4'b0000;
    cyc(12);
    chk("t5_count", 32'(en_cnt - e0), 32'd1);
    // asynchronous reset while the strobe is pending
    e0 = en_cnt;
    btn_raw = 4'b0001;
    cyc(7);
    chk("t6_setup_col", 32'(in_column), 32'hE);
    reset = 1'b0;
    #1;
    chk("t6_rst_col", 32'(in_column), 32'hF);
    chk("t6_rst_en", 32'(enable), 32'h0);
    chk("t6_rst_err", 32'(err_multi), 32'h0);
    chk("t6_rst_db", 32'(btn_db), 32'h0);
    cyc(1);
    reset = 1'b1;
    cyc(2);
    btn_raw = 4'b0000;
    cyc(15);
    chk("t6_no_en", 32'(en_cnt - e0), 32'd0);
    // randomized segments with glitches, game-status changes and occasional resets
    for (int s = 0; s < 400; s++) begin
      int sel, len;
      logic [3:0] pat;
      sel = int'($urandom_range(0, 9));
      pat = (sel < 6) ? (4'b0001 << $urandom_range(0, 3)) :
            (sel < 8) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 3) == 0) game_status = 2'($urandom);
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        btn_raw = ($urandom_range(0, 6) == 0) ? 4'($urandom) : pat;
        if ($urandom_range(0, 199) == 0) begin
          reset = 1'b0;
          cyc(1);
          reset = 1'b1;
        end
        cyc(1);
      end
    end
    btn_raw = 4'b0000;
    cyc(12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
